// File: rtl/fdd_track_ctrl_pkg.sv
// Shared types and helpers for the floppy track-buffer controller.
// The track-to-LBA mapping is a shift-add so it needs no multiplier.
package fdd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_ACK,
    RD_REQ,
    RD_ACK
  } fdd_state_t;

  localparam int SECTORS_PER_TRACK = 13;

  function automatic logic [31:0] track_lba(input logic [31:0] t);
    return (t << 3) + (t << 2) + t;
  endfunction

endpackage

// File: rtl/fdd_track_ctrl_if.sv
// SD block channel between the track controller (master) and hps_io (slave).
interface fdd_track_ctrl_if;
  import fdd_pkg::*;

  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/fdd_track_ctrl_sd_sector_hs.sv
// One-sector request/ack handshake: holds rd/wr until ack rises, pulses done when ack falls.
module sd_sector_hs
  import fdd_pkg::*;
(
  input  logic clk_sys,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_write,
  input  logic i_ack,
  output logic o_rd,
  output logic o_wr,
  output logic o_ack_rise,
  output logic o_done
);

  logic r_ack_p0;
  logic r_ack_p1;
  logic r_rd;
  logic r_wr;
  logic w_rise;
  logic w_fall;

  // ack is registered before edge detection, so both edges act one cycle late
  assign w_rise = r_ack_p0 & ~r_ack_p1;
  assign w_fall = ~r_ack_p0 & r_ack_p1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_ack_p0 <= 1'b0;
      r_ack_p1 <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
    end else begin
      r_ack_p0 <= i_ack;
      r_ack_p1 <= r_ack_p0;
      if (w_rise) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
      end else if (i_start) begin
        r_rd <= ~i_is_write;
        r_wr <= i_is_write;
      end
    end
  end

  assign o_rd       = r_rd;
  assign o_wr       = r_wr;
  assign o_ack_rise = w_rise;
  assign o_done     = w_fall;

endmodule

// File: rtl/fdd_track_ctrl.sv
// Track-buffer sequencer for virtual disk 0: writes back a modified track,
// then loads the requested one, stalling the CPU while sectors move.
module fdd_track_ctrl
  import fdd_pkg::*;
#(
  parameter int SECTORS = SECTORS_PER_TRACK,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               buf_write,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  fdd_track_ctrl_if.master   sd,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               busy
);

  localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

  fdd_state_t         r_state, w_state_n;
  logic [TRACK_W-1:0] r_cur_track, w_cur_n;
  logic               r_present, w_present_n;
  logic               r_ro, w_ro_n;
  logic               r_dirty, w_dirty_n;
  logic               r_reload, w_reload_n;
  logic               r_abort, w_abort_n;
  logic [3:0]         r_sec, w_sec_n;
  logic [31:0]        r_base, w_base_n;
  logic [31:0]        r_lba, w_lba_n;
  logic               r_busy;
  logic               r_wait;

  logic w_start;
  logic w_is_write;
  logic w_ack_rise;
  logic w_done;
  logic w_rd;
  logic w_wr;
  logic w_abort;

  assign w_start    = (r_state == WB_REQ) || (r_state == RD_REQ);
  assign w_is_write = (r_state == WB_REQ);
  assign w_abort    = r_abort | img_mounted;

  sd_sector_hs u_hs (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .i_start    (w_start),
    .i_is_write (w_is_write),
    .i_ack      (sd.sd_ack),
    .o_rd       (w_rd),
    .o_wr       (w_wr),
    .o_ack_rise (w_ack_rise),
    .o_done     (w_done)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur_track <= '0;
      r_present   <= 1'b0;
      r_ro        <= 1'b0;
      r_dirty     <= 1'b0;
      r_reload    <= 1'b0;
      r_abort     <= 1'b0;
      r_sec       <= '0;
      r_lba       <= '0;
      r_busy      <= 1'b0;
      r_wait      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cur_track <= w_cur_n;
      r_present   <= w_present_n;
      r_ro        <= w_ro_n;
      r_dirty     <= w_dirty_n;
      r_reload    <= w_reload_n;
      r_abort     <= w_abort_n;
      r_sec       <= w_sec_n;
      r_lba       <= w_lba_n;
      r_busy      <= (w_state_n != IDLE);
      r_wait      <= (w_state_n != IDLE);
    end
  end

  always_ff @(posedge clk_sys) begin
    r_base <= w_base_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_cur_n     = r_cur_track;
    w_present_n = r_present;
    w_ro_n      = r_ro;
    w_dirty_n   = r_dirty;
    w_reload_n  = r_reload;
    w_abort_n   = r_abort;
    w_sec_n     = r_sec;
    w_base_n    = r_base;

    // a mount outranks a buffer write and cancels any sequence in flight
    if (img_mounted) begin
      w_present_n = img_present;
      w_ro_n      = img_readonly;
      w_dirty_n   = 1'b0;
      w_reload_n  = 1'b1;
      w_abort_n   = (r_state != IDLE);
    end else if (buf_write && r_present && !r_ro) begin
      w_dirty_n = 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_abort_n = 1'b0;
        if (!img_mounted && r_present && ((track != r_cur_track) || r_reload)) begin
          w_reload_n = 1'b0;
          w_sec_n    = '0;
          if (r_dirty) begin
            w_base_n  = track_lba(32'(r_cur_track));
            w_state_n = WB_REQ;
          end else begin
            w_cur_n   = track;
            w_base_n  = track_lba(32'(track));
            w_state_n = RD_REQ;
          end
        end
      end
      WB_REQ: if (w_ack_rise) w_state_n = WB_ACK;
      WB_ACK: begin
        if (w_done) begin
          if (w_abort) begin
            w_abort_n = 1'b0;
            w_state_n = IDLE;
          end else if (r_sec == LAST_SEC) begin
            w_dirty_n = 1'b0;
            w_cur_n   = track;
            w_base_n  = track_lba(32'(track));
            w_sec_n   = '0;
            w_state_n = RD_REQ;
          end else begin
            w_sec_n   = r_sec + 4'd1;
            w_state_n = WB_REQ;
          end
        end
      end
      RD_REQ: if (w_ack_rise) w_state_n = RD_ACK;
      RD_ACK: begin
        if (w_done) begin
          if (w_abort || (r_sec == LAST_SEC)) begin
            w_abort_n = 1'b0;
            w_state_n = IDLE;
          end else begin
            w_sec_n   = r_sec + 4'd1;
            w_state_n = RD_REQ;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    w_lba_n = ((w_state_n == WB_REQ) || (w_state_n == RD_REQ)) ? (w_base_n + 32'(w_sec_n)) : r_lba;
  end

  assign sd.sd_lba = r_lba;
  assign sd.sd_rd  = w_rd;
  assign sd.sd_wr  = w_wr;
  assign track_sec = r_sec;
  assign cpu_wait  = r_wait;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fdd_track_ctrl.sv
// Scoreboard bench: expected sector requests are queued with each stimulus and
// matched against what the controller issues to a modelled hps_io responder.
module tb_fdd_track_ctrl;

  typedef struct packed {
    logic        wr;
    logic [31:0] lba;
    logic [3:0]  sec;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] track = '0;
  logic       buf_write = 1'b0;
  logic       img_mounted = 1'b0;
  logic       img_present = 1'b0;
  logic       img_readonly = 1'b0;
  logic [3:0] track_sec;
  logic       cpu_wait;
  logic       busy;

  logic ack_auto = 1'b0;
  logic ack_man = 1'b0;
  logic auto_en = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  exp_t q[$];

  fdd_track_ctrl_if sd_if ();
  assign sd_if.sd_ack = ack_auto | ack_man;

  fdd_track_ctrl #(.SECTORS(13), .TRACK_W(6)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .track        (track),
    .buf_write    (buf_write),
    .img_mounted  (img_mounted),
    .img_present  (img_present),
    .img_readonly (img_readonly),
    .sd           (sd_if.master),
    .track_sec    (track_sec),
    .cpu_wait     (cpu_wait),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_seq(input logic wr, input int base);
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      e.wr  = wr;
      e.lba = 32'(base + i);
      e.sec = 4'(i);
      q.push_back(e);
    end
  endtask

  task automatic mount(input logic pres, input logic ro);
    @(negedge clk_sys);
    img_present  = pres;
    img_readonly = ro;
    img_mounted  = 1'b1;
    @(negedge clk_sys);
    img_mounted  = 1'b0;
  endtask

  task automatic pulse_write();
    @(negedge clk_sys);
    buf_write = 1'b1;
    @(negedge clk_sys);
    buf_write = 1'b0;
  endtask

  task automatic run_until_idle(input string tag);
    int k;
    repeat (4) @(negedge clk_sys);
    k = 0;
    while ((busy || q.size() != 0) && k < 3000) begin
      @(negedge clk_sys);
      k++;
    end
    check({tag, "_in_time"}, 32'(k < 3000), 32'd1);
    check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
    check({tag, "_cpu_wait_low"}, 32'(cpu_wait), 32'd0);
  endtask

  // hps_io model: acknowledges each request and checks it against the scoreboard
  initial begin : responder
    exp_t        e;
    logic        got_wr;
    logic [31:0] got_lba;
    logic [3:0]  got_sec;
    int          k;
    forever begin
      @(negedge clk_sys);
      if (auto_en && (sd_if.sd_rd || sd_if.sd_wr)) begin
        got_wr  = sd_if.sd_wr;
        got_lba = sd_if.sd_lba;
        got_sec = track_sec;
        check("req_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("req_is_write", 32'(got_wr), 32'(e.wr));
          check("req_lba", got_lba, e.lba);
          check("req_track_sec", 32'(got_sec), 32'(e.sec));
        end
        check("req_cpu_wait", 32'(cpu_wait), 32'd1);
        @(negedge clk_sys);
        ack_auto = 1'b1;
        @(posedge clk_sys);
        #1 check("req_held_at_ack_edge", 32'(sd_if.sd_rd | sd_if.sd_wr), 32'd1);
        @(posedge clk_sys);
        #1 check("req_low_after_ack", 32'(sd_if.sd_rd | sd_if.sd_wr), 32'd0);
        k = 0;
        while ((sd_if.sd_rd || sd_if.sd_wr) && k < 20) begin
          @(negedge clk_sys);
          k++;
        end
        repeat (2) @(negedge clk_sys);
        check("lba_stable", sd_if.sd_lba, got_lba);
        ack_auto = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1);
  end

  initial begin : main
    int k;
    int seen;

    repeat (3) @(negedge clk_sys);
    check("rst_sd_rd", 32'(sd_if.sd_rd), 32'd0);
    check("rst_sd_wr", 32'(sd_if.sd_wr), 32'd0);
    check("rst_sd_lba", sd_if.sd_lba, 32'd0);
    check("rst_track_sec", 32'(track_sec), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Mount RW image on track 0: full load of LBA 0..12
    push_seq(1'b0, 0);
    mount(1'b1, 1'b0);
    run_until_idle("mount_load");
    check("mount_load_busy", 32'(busy), 32'd0);

    // Clean buffer, 0 -> 5: reads only, with request latency checked
    push_seq(1'b0, 65);
    @(negedge clk_sys);
    track = 6'd5;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    check("lat_sd_rd", 32'(sd_if.sd_rd), 32'd1);
    check("lat_sd_lba", sd_if.sd_lba, 32'd65);
    check("lat_cpu_wait", 32'(cpu_wait), 32'd1);
    run_until_idle("track5");

    // Dirty track 5, step to 6: write back 65..77 then read 78..90
    pulse_write();
    push_seq(1'b1, 65);
    push_seq(1'b0, 78);
    @(negedge clk_sys);
    track = 6'd6;
    run_until_idle("writeback");

    // dirty must be clear now: 6 -> 7 reads only
    push_seq(1'b0, 91);
    @(negedge clk_sys);
    track = 6'd7;
    run_until_idle("after_wb");

    // Read-only image: reload, writes ignored, no write-back on step
    push_seq(1'b0, 91);
    mount(1'b1, 1'b1);
    run_until_idle("ro_reload");
    pulse_write();
    pulse_write();
    pulse_write();
    push_seq(1'b0, 104);
    @(negedge clk_sys);
    track = 6'd8;
    run_until_idle("ro_step");

    // back to RW image; reload the current track
    push_seq(1'b0, 104);
    mount(1'b1, 1'b0);
    run_until_idle("rw_reload");

    // Step to 1, then to 2 during the 4th sector: both loads run in order
    push_seq(1'b0, 13);
    push_seq(1'b0, 26);
    @(negedge clk_sys);
    track = 6'd1;
    k = 0;
    while (!(sd_if.sd_rd && track_sec == 4'd3) && k < 2000) begin
      @(negedge clk_sys);
      k++;
    end
    check("mid_step_reached", 32'(k < 2000), 32'd1);
    track = 6'd2;
    run_until_idle("mid_step");

    // Reset while in write-back ack phase with ack held high
    auto_en = 1'b0;
    pulse_write();
    @(negedge clk_sys);
    track = 6'd3;
    k = 0;
    while (!sd_if.sd_wr && k < 200) begin
      @(negedge clk_sys);
      k++;
    end
    check("wb_started", 32'(sd_if.sd_wr), 32'd1);
    check("wb_lba", sd_if.sd_lba, 32'd26);
    ack_man = 1'b1;
    k = 0;
    while (sd_if.sd_wr && k < 50) begin
      @(negedge clk_sys);
      k++;
    end
    check("wb_req_dropped", 32'(sd_if.sd_wr), 32'd0);
    check("wb_busy", 32'(busy), 32'd1);
    @(negedge clk_sys);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("rst_mid_sd_wr", 32'(sd_if.sd_wr), 32'd0);
    check("rst_mid_cpu_wait", 32'(cpu_wait), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    ack_man = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (sd_if.sd_rd || sd_if.sd_wr || cpu_wait) seen++;
    end
    check("no_req_after_reset", 32'(seen), 32'd0);

    // No image present: track change issues nothing
    track = 6'd9;
    seen = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (sd_if.sd_rd || sd_if.sd_wr || cpu_wait || busy) seen++;
    end
    check("absent_no_activity", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
